// File: rtl/mole_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mole_scheduler
// Purpose  : Mole game scheduler. Waits a random gap, spawns a mole in a
//            random hole, keeps it up for a fixed time and resolves the
//            appearance as a hit (correct-hole press) or a miss (timeout).
// Option   : MOLE_NO_REPEAT_EN - when defined, a spawn never reuses the hole
//            of the previous spawn (only after the first spawn since IDLE).
// Revision : 1.0 - initial release
// ============================================================================
module mole_scheduler #(
  parameter int NUM_HOLES  = 9,
  parameter int PRESCALE   = 1000,
  parameter int GAP_MIN_MS = 200,
  parameter int UP_MS      = 800
) (
  input  logic                 clk_1mhz,
  input  logic                 rst,
  input  logic                 game_en,
  input  logic [8:0]           rand_num,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [3:0]           hole_idx,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 busy
);

  // Counter widths: the gap counter must hold GAP_MIN_MS + 511 and is never
  // narrower than 10 bits; the up counter only has to hold UP_MS.
  localparam int c_PRESC_W = $clog2(PRESCALE);
  localparam int c_GAP_RAW = $clog2(GAP_MIN_MS + 512);
  localparam int c_GAP_W   = (c_GAP_RAW < 10) ? 10 : c_GAP_RAW;
  localparam int c_UP_W    = $clog2(UP_MS + 1);

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);
  localparam logic [c_GAP_W-1:0]   c_GAP_MIN    = c_GAP_W'(GAP_MIN_MS);
  localparam logic [c_UP_W-1:0]    c_UP_LOAD    = c_UP_W'(UP_MS);
  localparam logic [4:0]           c_NH         = 5'(NUM_HOLES);
  localparam logic [3:0]           c_LAST_IDX   = 4'(NUM_HOLES - 1);
  localparam logic [NUM_HOLES-1:0] c_ONE        = NUM_HOLES'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_SPAWN = 2'd2,
    S_UP    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_PRESC_W-1:0]   r_presc;
  logic [c_PRESC_W-1:0]   w_presc_nxt;
  logic [c_GAP_W-1:0]     r_gap_cnt;
  logic [c_GAP_W-1:0]     w_gap_nxt;
  logic [c_UP_W-1:0]      r_up_cnt;
  logic [c_UP_W-1:0]      w_up_nxt;
  logic [NUM_HOLES-1:0]   w_mole_nxt;
  logic [3:0]             w_idx_nxt;
  logic                   w_hit_nxt;
  logic                   w_miss_nxt;
  logic                   w_tick;
  logic                   w_hit;
  logic [c_GAP_W-1:0]     w_gap_load;
  logic [4:0]             w_r5;
  logic [3:0]             w_raw_idx;
  logic [3:0]             w_spawn_idx;

  // While a mole is up, mole_onehot marks exactly the hole_idx bit, so the
  // correct-hole press is simply any overlap between btn and the mole.
  assign w_hit      = |(btn & mole_onehot);
  assign w_tick     = (r_state != S_IDLE) && (r_presc == c_PRESC_LAST);
  assign w_gap_load = c_GAP_MIN + c_GAP_W'(rand_num);

`ifdef MOLE_NO_REPEAT_EN
  logic r_prev_valid;

  // Previous hole becomes meaningful only after the first spawn since IDLE.
  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
    end else if (!game_en || (r_state == S_IDLE)) begin
      r_prev_valid <= 1'b0;
    end else if (r_state == S_SPAWN) begin
      r_prev_valid <= 1'b1;
    end
  end
`endif

  // Fold the 4-bit random value into the hole range, optionally avoiding a repeat.
  always_comb begin
    w_r5      = {1'b0, rand_num[3:0]};
    w_raw_idx = rand_num[3:0];
    if (w_r5 >= c_NH) begin
      w_raw_idx = 4'(w_r5 - c_NH);
    end
`ifdef MOLE_NO_REPEAT_EN
    w_spawn_idx = w_raw_idx;
    if (r_prev_valid && (w_raw_idx == hole_idx)) begin
      w_spawn_idx = (hole_idx == c_LAST_IDX) ? 4'd0 : (hole_idx + 4'd1);
    end
`else
    w_spawn_idx = w_raw_idx;
`endif
  end

  // Next-state and next-output logic; game_en low overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_up_nxt    = r_up_cnt;
    w_mole_nxt  = mole_onehot;
    w_idx_nxt   = hole_idx;
    w_hit_nxt   = 1'b0;
    w_miss_nxt  = 1'b0;
    w_presc_nxt = '0;

    if (game_en && (r_state != S_IDLE)) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
    end

    if (!game_en) begin
      w_state_nxt = S_IDLE;
      w_mole_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_mole_nxt  = '0;
          w_gap_nxt   = w_gap_load;
          w_state_nxt = S_GAP;
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gap_cnt <= c_GAP_W'(1)) begin
              w_state_nxt = S_SPAWN;
            end else begin
              w_gap_nxt = r_gap_cnt - 1'b1;
            end
          end
        end
        S_SPAWN: begin
          w_idx_nxt   = w_spawn_idx;
          w_up_nxt    = c_UP_LOAD;
          w_mole_nxt  = c_ONE << w_spawn_idx;
          w_state_nxt = S_UP;
        end
        S_UP: begin
          if (w_hit) begin
            // A correct press wins even on the expiry tick.
            w_hit_nxt   = 1'b1;
            w_mole_nxt  = '0;
            w_gap_nxt   = w_gap_load;
            w_state_nxt = S_GAP;
          end else if (w_tick) begin
            if (r_up_cnt <= c_UP_W'(1)) begin
              w_miss_nxt  = 1'b1;
              w_mole_nxt  = '0;
              w_gap_nxt   = w_gap_load;
              w_state_nxt = S_GAP;
            end else begin
              w_up_nxt = r_up_cnt - 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_mole_nxt  = '0;
        end
      endcase
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_gap_cnt   <= '0;
      r_up_cnt    <= '0;
      mole_onehot <= '0;
      hole_idx    <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_up_cnt    <= w_up_nxt;
      mole_onehot <= w_mole_nxt;
      hole_idx    <= w_idx_nxt;
      hit_pulse   <= w_hit_nxt;
      miss_pulse  <= w_miss_nxt;
      busy        <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mole_scheduler
// Purpose  : Directed bench for mole_scheduler with PRESCALE=4, GAP_MIN_MS=2,
//            UP_MS=5, NUM_HOLES=9. Edge numbers in comments count from the
//            IDLE->GAP edge (E1). Honours MOLE_NO_REPEAT_EN for the repeat case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

  logic       clk_1mhz;
  logic       rst;
  logic       game_en;
  logic [8:0] rand_num;
  logic [8:0] btn;
  logic [8:0] mole_onehot;
  logic [3:0] hole_idx;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       busy;

  int checks;
  int failures;

  // Second spawn draws hole 3 again; with the no-repeat option it moves to 4.
`ifdef MOLE_NO_REPEAT_EN
  localparam logic [3:0] c_EXP_IDX2  = 4'd4;
  localparam logic [8:0] c_EXP_MOLE2 = 9'h010;
`else
  localparam logic [3:0] c_EXP_IDX2  = 4'd3;
  localparam logic [8:0] c_EXP_MOLE2 = 9'h008;
`endif

  mole_scheduler #(
    .NUM_HOLES  (9),
    .PRESCALE   (4),
    .GAP_MIN_MS (2),
    .UP_MS      (5)
  ) dut (
    .clk_1mhz    (clk_1mhz),
    .rst         (rst),
    .game_en     (game_en),
    .rand_num    (rand_num),
    .btn         (btn),
    .mole_onehot (mole_onehot),
    .hole_idx    (hole_idx),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .busy        (busy)
  );

  initial clk_1mhz = 1'b0;
  always #5 clk_1mhz = ~clk_1mhz;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1mhz);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    game_en  = 1'b0;
    rand_num = 9'h000;
    btn      = 9'h000;

    // Reset state
    step_n(3);
    check("rst_mole", 16'(mole_onehot), 16'h0);
    check("rst_idx",  16'(hole_idx),    16'h0);
    check("rst_hit",  16'(hit_pulse),   16'h0);
    check("rst_miss", 16'(miss_pulse),  16'h0);
    check("rst_busy", 16'(busy),        16'h0);
    rst = 1'b0;
    step_n(1);
    check("idle_busy", 16'(busy), 16'h0);

    // Start: gap = 2 + 3 = 5 ticks = 20 cycles
    game_en  = 1'b1;
    rand_num = 9'h003;
    step_n(1);                                   // E1
    check("e1_busy", 16'(busy), 16'h1);
    check("e1_mole", 16'(mole_onehot), 16'h0);
    step_n(20);                                  // E21: in SPAWN
    check("spawn_mole_zero", 16'(mole_onehot), 16'h0);
    check("spawn_busy", 16'(busy), 16'h1);
    step_n(1);                                   // E22: UP, hole 3
    check("up1_mole", 16'(mole_onehot), 16'h008);
    check("up1_idx",  16'(hole_idx),    16'h3);

    // No press: miss after 5 ticks at E41
    step_n(18);                                  // E40
    check("pre_miss_mole", 16'(mole_onehot), 16'h008);
    check("pre_miss_pulse", 16'(miss_pulse), 16'h0);
    step_n(1);                                   // E41
    check("miss_pulse", 16'(miss_pulse), 16'h1);
    check("miss_mole",  16'(mole_onehot), 16'h0);
    check("miss_nohit", 16'(hit_pulse), 16'h0);
    rand_num = 9'h00C;                           // spawn value 12 -> hole 3
    step_n(1);                                   // E42
    check("miss_one_cycle", 16'(miss_pulse), 16'h0);
    check("miss_to_gap_busy", 16'(busy), 16'h1);
    step_n(20);                                  // E62: UP
    check("up2_mole", 16'(mole_onehot), 16'(c_EXP_MOLE2));
    check("up2_idx",  16'(hole_idx),    16'(c_EXP_IDX2));

    // Wrong hole pressed: ignored
    step_n(1);                                   // E63
    btn = 9'h020;
    step_n(1);                                   // E64
    check("wrong_btn_hit",  16'(hit_pulse),   16'h0);
    check("wrong_btn_miss", 16'(miss_pulse),  16'h0);
    check("wrong_btn_mole", 16'(mole_onehot), 16'(c_EXP_MOLE2));

    // Correct hole pressed mid-UP; new gap = 2 + 0
    btn      = c_EXP_MOLE2;
    rand_num = 9'h000;
    step_n(1);                                   // E65
    check("hit_pulse", 16'(hit_pulse),   16'h1);
    check("hit_mole",  16'(mole_onehot), 16'h0);
    check("hit_nomiss", 16'(miss_pulse), 16'h0);
    btn      = 9'h000;
    rand_num = 9'h00F;                           // spawn value 15 -> hole 6
    step_n(1);                                   // E66
    check("hit_one_cycle", 16'(hit_pulse), 16'h0);
    step_n(7);                                   // E73: SPAWN
    check("spawn3_mole_zero", 16'(mole_onehot), 16'h0);
    step_n(1);                                   // E74: UP, hole 6
    check("up3_mole", 16'(mole_onehot), 16'h040);
    check("up3_idx",  16'(hole_idx),    16'h6);

    // Correct press on the expiry-tick cycle: hit only
    step_n(18);                                  // E92
    check("pre_exp_mole", 16'(mole_onehot), 16'h040);
    check("pre_exp_miss", 16'(miss_pulse),  16'h0);
    btn      = 9'h040;
    rand_num = 9'h000;
    step_n(1);                                   // E93
    check("exp_hit",    16'(hit_pulse),   16'h1);
    check("exp_nomiss", 16'(miss_pulse),  16'h0);
    check("exp_mole",   16'(mole_onehot), 16'h0);
    btn      = 9'h000;
    rand_num = 9'h008;                           // spawn value 8 -> hole 8
    step_n(1);                                   // E94
    check("exp_after_hit",  16'(hit_pulse),  16'h0);
    check("exp_after_miss", 16'(miss_pulse), 16'h0);
    step_n(7);                                   // E101: SPAWN
    check("spawn4_mole_zero", 16'(mole_onehot), 16'h0);
    step_n(1);                                   // E102: UP, hole 8
    check("up4_mole", 16'(mole_onehot), 16'h100);
    check("up4_idx",  16'(hole_idx),    16'h8);

    // game_en dropped during UP
    step_n(1);                                   // E103
    game_en = 1'b0;
    step_n(1);                                   // E104
    check("dis_busy", 16'(busy),        16'h0);
    check("dis_mole", 16'(mole_onehot), 16'h0);
    check("dis_hit",  16'(hit_pulse),   16'h0);
    check("dis_miss", 16'(miss_pulse),  16'h0);
    check("dis_idx",  16'(hole_idx),    16'h8);
    step_n(1);
    check("dis_stay_idle", 16'(busy), 16'h0);

    // Async reset in the middle of GAP
    game_en  = 1'b1;
    rand_num = 9'h010;
    step_n(1);
    check("regap_busy", 16'(busy), 16'h1);
    step_n(3);
    rst = 1'b1;
    #2;
    check("arst_busy", 16'(busy),        16'h0);
    check("arst_idx",  16'(hole_idx),    16'h0);
    check("arst_mole", 16'(mole_onehot), 16'h0);
    check("arst_hit",  16'(hit_pulse),   16'h0);
    check("arst_miss", 16'(miss_pulse),  16'h0);
    step_n(2);
    rst = 1'b0;
    step_n(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
